// File: rtl/mips_defs_pkg.sv
// Shared MIPS datapath definitions: ALU function codes, forward-select encoding
// and the hard-wired zero register index.
package mips_defs_pkg;

    localparam logic [5:0] ALUFUNC_ADD = 6'b000000;
    localparam logic [5:0] ALUFUNC_SUB = 6'b000001;
    localparam logic [5:0] ALUFUNC_AND = 6'b000100;
    localparam logic [5:0] ALUFUNC_OR  = 6'b000101;
    localparam logic [5:0] ALUFUNC_XOR = 6'b000110;
    localparam logic [5:0] ALUFUNC_SLL = 6'b100000;
    localparam logic [5:0] ALUFUNC_SRL = 6'b100001;
    localparam logic [5:0] ALUFUNC_SRA = 6'b100011;

    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand RAW forwarding mux: MEM result beats WB result beats the latched
// regfile value; register $0 always reads zero.
module operand_fwd_mux
    import mips_defs_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
)
(
    input  logic [AW-1:0] src,
    input  logic [DW-1:0] latched,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_wr_addr,
    input  logic [DW-1:0] mem_wr_data,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_wr_addr,
    input  logic [DW-1:0] wb_wr_data,
    output logic [DW-1:0] data,
    output fwd_sel_e      sel
);

    always_comb begin
        sel  = FWD_REG;
        data = latched;
        if (src == AW'(REG_ZERO)) begin
            data = '0;
        end else if (mem_reg_write && (mem_wr_addr == src)) begin
            sel  = FWD_MEM;
            data = mem_wr_data;
        end else if (wb_reg_write && (wb_wr_addr == src)) begin
            sel  = FWD_WB;
            data = wb_wr_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, A/B operand select
// and load-use hazard detection feeding the ALU.
module id_ex_operand_stage
    import mips_defs_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int FW = 6
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs_addr,
    input  logic [AW-1:0] id_rt_addr,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_shamt,
    input  logic          id_asel_shamt,
    input  logic          id_bsel_imm,
    input  logic          id_signed,
    input  logic [FW-1:0] id_alufunc,
    input  logic [AW-1:0] id_wr_addr,
    input  logic          id_reg_write,
    input  logic          id_mem_read,
    input  logic          ex_hold,
    input  logic          ex_flush,
    input  logic          mem_reg_write,
    input  logic [AW-1:0] mem_wr_addr,
    input  logic [DW-1:0] mem_wr_data,
    input  logic          wb_reg_write,
    input  logic [AW-1:0] wb_wr_addr,
    input  logic [DW-1:0] wb_wr_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_signed,
    output logic [FW-1:0] alu_func,
    output logic          ex_valid,
    output logic [AW-1:0] ex_wr_addr,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic [DW-1:0] ex_store_data,
    output logic          load_use_stall
);

    logic               vld_p1;
    logic [AW-1:0]      rs_addr_p1;
    logic [AW-1:0]      rt_addr_p1;
    logic [DW-1:0]      rs_data_p1;
    logic [DW-1:0]      rt_data_p1;
    logic [DW-1:0]      imm_p1;
    logic [SHAMT_W-1:0] shamt_p1;
    logic               asel_shamt_p1;
    logic               bsel_imm_p1;
    logic               signed_p1;
    logic [FW-1:0]      alufunc_p1;
    logic [AW-1:0]      wr_addr_p1;
    logic               reg_write_p1;
    logic               mem_read_p1;

    logic [DW-1:0]      fwd_rs;
    logic [DW-1:0]      fwd_rt;
    fwd_sel_e           rs_sel;
    fwd_sel_e           rt_sel;
    logic               rs_conflict;
    logic               rt_conflict;

    operand_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .src           (rs_addr_p1),
        .latched       (rs_data_p1),
        .mem_reg_write (mem_reg_write),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .wb_wr_data    (wb_wr_data),
        .data          (fwd_rs),
        .sel           (rs_sel)
    );

    operand_fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .src           (rt_addr_p1),
        .latched       (rt_data_p1),
        .mem_reg_write (mem_reg_write),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .wb_wr_data    (wb_wr_data),
        .data          (fwd_rt),
        .sel           (rt_sel)
    );

    assign rs_conflict    = id_uses_rs && (id_rs_addr == wr_addr_p1);
    assign rt_conflict    = id_uses_rt && (id_rt_addr == wr_addr_p1);
    assign load_use_stall = id_valid && vld_p1 && mem_read_p1 &&
                            (wr_addr_p1 != AW'(REG_ZERO)) && (rs_conflict || rt_conflict);

    // ID -> EX register (p1)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1        <= 1'b0;
            rs_addr_p1    <= '0;
            rt_addr_p1    <= '0;
            rs_data_p1    <= '0;
            rt_data_p1    <= '0;
            imm_p1        <= '0;
            shamt_p1      <= '0;
            asel_shamt_p1 <= 1'b0;
            bsel_imm_p1   <= 1'b0;
            signed_p1     <= 1'b0;
            alufunc_p1    <= ALUFUNC_ADD;
            wr_addr_p1    <= '0;
            reg_write_p1  <= 1'b0;
            mem_read_p1   <= 1'b0;
        end else if (ex_flush) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else if (ex_hold) begin
            // Capture forwarded values so they survive MEM/WB retiring during the hold.
            if (rs_sel != FWD_REG) rs_data_p1 <= fwd_rs;
            if (rt_sel != FWD_REG) rt_data_p1 <= fwd_rt;
        end else if (load_use_stall) begin
            vld_p1       <= 1'b0;
            reg_write_p1 <= 1'b0;
            mem_read_p1  <= 1'b0;
        end else begin
            vld_p1        <= id_valid;
            rs_addr_p1    <= id_rs_addr;
            rt_addr_p1    <= id_rt_addr;
            rs_data_p1    <= id_rs_data;
            rt_data_p1    <= id_rt_data;
            imm_p1        <= id_imm;
            shamt_p1      <= id_shamt;
            asel_shamt_p1 <= id_asel_shamt;
            bsel_imm_p1   <= id_bsel_imm;
            signed_p1     <= id_signed;
            alufunc_p1    <= id_alufunc;
            wr_addr_p1    <= id_wr_addr;
            reg_write_p1  <= id_reg_write;
            mem_read_p1   <= id_mem_read;
        end
    end

    // EX operand select (combinational after p1)
    assign alu_a         = asel_shamt_p1 ? {{(DW-SHAMT_W){1'b0}}, shamt_p1} : fwd_rs;
    assign alu_b         = bsel_imm_p1 ? imm_p1 : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign alu_signed    = signed_p1;
    assign alu_func      = alufunc_p1;
    assign ex_valid      = vld_p1;
    assign ex_wr_addr    = wr_addr_p1;
    assign ex_reg_write  = vld_p1 && reg_write_p1;
    assign ex_mem_read   = vld_p1 && mem_read_p1;

endmodule
